// File: rtl/prog_loader.sv
// Program loader: assembles a framed UART byte stream (A5, N, N words hi/lo, XOR checksum)
// into instruction words and writes them to program memory while holding the CPU.
module prog_loader #(
    parameter int ADDR_WIDTH  = 4,
    parameter int INSTR_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_waddr,
    output logic [INSTR_WIDTH-1:0] mem_wdata,
    output logic                   cpu_hold,
    output logic                   load_done,
    output logic                   load_error
);
    localparam int CW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_CHECK} state_t;

    state_t                 state_q;
    logic [CW-1:0]          idx_q, n_q;
    logic [INSTR_WIDTH-9:0] hi_q;
    logic [7:0]             xor_q;
    logic                   rdy_q, we_q, hold_q, done_q, err_q;
    logic [ADDR_WIDTH-1:0]  waddr_q;
    logic [INSTR_WIDTH-1:0] wdata_q;

    logic          accept;
    logic [CW-1:0] idx_d;
    logic [7:0]    xor_d;

    assign accept = rx_valid && rdy_q;
    assign idx_d  = idx_q + CW'(1);
    assign xor_d  = xor_q ^ rx_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            hi_q    <= '0;
            xor_q   <= '0;
            rdy_q   <= 1'b1;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            we_q   <= 1'b0;
            case (state_q)
                S_IDLE: if (accept && rx_data == 8'hA5) begin
                    state_q <= S_COUNT;
                    hold_q  <= 1'b1;
                    err_q   <= 1'b0;
                    idx_q   <= '0;
                    xor_q   <= '0;
                end
                S_COUNT: if (accept) begin
                    xor_q <= xor_d;
                    if (int'(rx_data) > DEPTH) begin
                        err_q   <= 1'b1;
                        hold_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (rx_data == 8'h00) begin
                        state_q <= S_CHECK;
                    end else begin
                        n_q     <= CW'(rx_data);
                        state_q <= S_HI;
                    end
                end
                S_HI: if (accept) begin
                    hi_q    <= rx_data[INSTR_WIDTH-9:0];
                    xor_q   <= xor_d;
                    state_q <= S_LO;
                end
                // Write strobe is registered here so it is high for the whole WRITE cycle.
                S_LO: if (accept) begin
                    xor_q   <= xor_d;
                    we_q    <= 1'b1;
                    waddr_q <= idx_q[ADDR_WIDTH-1:0];
                    wdata_q <= {hi_q, rx_data};
                    rdy_q   <= 1'b0;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    idx_q   <= idx_d;
                    rdy_q   <= 1'b1;
                    state_q <= (idx_d == n_q) ? S_CHECK : S_HI;
                end
                S_CHECK: if (accept) begin
                    hold_q  <= 1'b0;
                    if (rx_data == xor_q) done_q <= 1'b1;
                    else                  err_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rx_ready   = rdy_q;
    assign mem_we     = we_q;
    assign mem_waddr  = waddr_q;
    assign mem_wdata  = wdata_q;
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_error = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (ADDR_WIDTH=4, INSTR_WIDTH=12).
module tb_prog_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready, mem_we, cpu_hold, load_done, load_error;
    logic [3:0]  mem_waddr;
    logic [11:0] mem_wdata;

    prog_loader #(.ADDR_WIDTH(4), .INSTR_WIDTH(12)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .load_done(load_done),
        .load_error(load_error)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int done_cnt = 0;
    int rdylo_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Write/pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa_q.push_back(32'(mem_waddr));
            wd_q.push_back(32'(mem_wdata));
        end
        if (load_done === 1'b1) done_cnt++;
        if (rx_ready === 1'b0) rdylo_cnt++;
    end

    task automatic clr();
        wa_q.delete();
        wd_q.delete();
        done_cnt  = 0;
        rdylo_cnt = 0;
    endtask

    // Returns at the negedge just after the byte was accepted.
    task automatic send(input logic [7:0] b, input int gap);
        int k;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        k = 0;
        while (rx_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) chk("send_timeout", 32'(rx_ready), 1);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'hA5;
    endtask

    function automatic int g(input int maxgap);
        return (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap));
    endfunction

    task automatic good_frame(input string tag, input int maxgap);
        send(8'hA5, g(maxgap));
        chk({tag, "_hold_hdr"}, 32'(cpu_hold), 1);
        chk({tag, "_err_clr"}, 32'(load_error), 0);
        send(8'h02, g(maxgap));
        send(8'h0A, g(maxgap));
        send(8'hBC, g(maxgap));
        chk({tag, "_we0"}, 32'(mem_we), 1);
        chk({tag, "_rdy0"}, 32'(rx_ready), 0);
        chk({tag, "_wa0"}, 32'(mem_waddr), 0);
        chk({tag, "_wd0"}, 32'(mem_wdata), 'hABC);
        chk({tag, "_hold_mid"}, 32'(cpu_hold), 1);
        send(8'h01, g(maxgap));
        send(8'h23, g(maxgap));
        chk({tag, "_we1"}, 32'(mem_we), 1);
        chk({tag, "_wa1"}, 32'(mem_waddr), 1);
        chk({tag, "_wd1"}, 32'(mem_wdata), 'h123);
        send(8'h96, g(maxgap));
        chk({tag, "_done"}, 32'(load_done), 1);
        chk({tag, "_hold_end"}, 32'(cpu_hold), 0);
        chk({tag, "_err"}, 32'(load_error), 0);
        @(negedge clk);
        chk({tag, "_done_once"}, 32'(done_cnt), 1);
        chk({tag, "_nwr"}, 32'(wa_q.size()), 2);
        chk({tag, "_rdy_low"}, 32'(rdylo_cnt), 2);
        if (wa_q.size() == 2) begin
            chk({tag, "_q_wa0"}, wa_q[0], 0);
            chk({tag, "_q_wd0"}, wd_q[0], 'hABC);
            chk({tag, "_q_wa1"}, wa_q[1], 1);
            chk({tag, "_q_wd1"}, wd_q[1], 'h123);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end

    initial begin
        logic [7:0] x, hi, lo;
        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(rx_ready), 1);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_waddr", 32'(mem_waddr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_hold", 32'(cpu_hold), 0);
        chk("rst_done", 32'(load_done), 0);
        chk("rst_err", 32'(load_error), 0);
        reset    = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_hold", 32'(cpu_hold), 0);
        clr();

        good_frame("good", 0);

        // Bad checksum: expected XOR is 01^FA^55 = AE, 00 is sent.
        clr();
        send(8'hA5, 0); send(8'h01, 0); send(8'hFA, 0); send(8'h55, 0);
        chk("bad_wa", 32'(mem_waddr), 0);
        chk("bad_wd", 32'(mem_wdata), 'hA55);
        send(8'h00, 0);
        chk("bad_err", 32'(load_error), 1);
        chk("bad_hold", 32'(cpu_hold), 0);
        chk("bad_done", 32'(load_done), 0);
        repeat (3) @(negedge clk);
        chk("bad_err_sticky", 32'(load_error), 1);
        chk("bad_done_cnt", 32'(done_cnt), 0);
        chk("bad_nwr", 32'(wa_q.size()), 1);
        send(8'hA5, 0);
        chk("bad_err_cleared", 32'(load_error), 0);
        send(8'h01, 0); send(8'h12, 0); send(8'h34, 0);
        chk("rec_wd", 32'(mem_wdata), 'h234);
        send(8'h27, 0);
        chk("rec_done", 32'(load_done), 1);

        // Oversize count, then a zero-word frame.
        clr();
        send(8'hA5, 0); send(8'h11, 0);
        chk("ovr_err", 32'(load_error), 1);
        chk("ovr_hold", 32'(cpu_hold), 0);
        chk("ovr_ready", 32'(rx_ready), 1);
        send(8'hA5, 0);
        chk("ovr_rehdr_hold", 32'(cpu_hold), 1);
        chk("ovr_rehdr_err", 32'(load_error), 0);
        send(8'h00, 0); send(8'h00, 0);
        chk("zero_done", 32'(load_done), 1);
        @(negedge clk);
        chk("zero_nwr", 32'(wa_q.size()), 0);

        // Junk in IDLE, then the good frame with random gaps.
        clr();
        send(8'h00, 0); send(8'hFF, 1); send(8'h3C, 2);
        chk("junk_hold", 32'(cpu_hold), 0);
        good_frame("gap", 5);

        // Full-depth load: 16 words, addresses 0..15.
        clr();
        send(8'hA5, 0); send(8'h10, 0);
        x = 8'h10;
        for (int i = 0; i < 16; i++) begin
            hi = 8'hF0 | 8'(i);
            lo = 8'(i * 17);
            x  = x ^ hi ^ lo;
            send(hi, 0); send(lo, 0);
            chk($sformatf("full_wa%0d", i), 32'(mem_waddr), 32'(i));
            chk($sformatf("full_wd%0d", i), 32'(mem_wdata), 32'({4'(i), lo}));
        end
        send(x, 0);
        chk("full_done", 32'(load_done), 1);
        @(negedge clk);
        chk("full_nwr", 32'(wa_q.size()), 16);

        // Reset after the 3rd word of a 5-word frame.
        clr();
        send(8'hA5, 0); send(8'h05, 0);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
        send(8'h44, 0); send(8'h55, 0); send(8'h66, 0);
        @(negedge clk);
        chk("mid_nwr3", 32'(wa_q.size()), 3);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("mid_hold", 32'(cpu_hold), 0);
        chk("mid_ready", 32'(rx_ready), 1);
        send(8'h77, 0); send(8'h88, 0);
        @(negedge clk);
        chk("mid_no_more", 32'(wa_q.size()), 3);
        clr();
        send(8'hA5, 0); send(8'h01, 0); send(8'h77, 0); send(8'h88, 0);
        chk("new_wa", 32'(mem_waddr), 0);
        chk("new_wd", 32'(mem_wdata), 'h788);
        send(8'hFE, 0);
        chk("new_done", 32'(load_done), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Write-side counterpart to the CPU's instruction ROM read path.
- Receives a framed byte stream from a UART receiver, assembles instruction words, and writes them into the writable program memory's write port.
- Holds the CPU while the load is in progress, then signals completion or error.

Parameters:
ADDR_WIDTH, 4, program memory address width; depth = 2**ADDR_WIDTH words.
INSTR_WIDTH, 12, instruction width; legal range 9..16; each word is sent as two bytes.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
rx_data  in  8  incoming byte
rx_valid  in  1  rx_data valid this cycle
rx_ready  out  1  loader can accept a byte; a byte transfers when rx_valid && rx_ready
mem_we  out  1  program memory write enable, one-cycle pulse per word
mem_waddr  out  ADDR_WIDTH  write address
mem_wdata  out  INSTR_WIDTH  write data
cpu_hold  out  1  high while a load is active; CPU stalls its PC
load_done  out  1  one-cycle pulse when a load completes with a good checksum
load_error  out  1  sticky error flag, cleared when the next header byte is accepted

Behaviour:
- Frame format: 0xA5 header, count byte N, N words (high byte then low byte each), checksum byte.
- Checksum = XOR of the count byte and all 2N data bytes.
- Reset values: rx_ready=1, mem_we=0, mem_waddr=0, mem_wdata=0, cpu_hold=0, load_done=0, load_error=0.
- Reset also sets state=IDLE, word index=0, running XOR=0.
- Reset mid-frame abandons the frame with no further writes; the next load starts at address 0.
- States: IDLE, COUNT, HI, LO, WRITE, CHECK.
- IDLE:
  - Accepted byte 0xA5 -> COUNT, cpu_hold=1, load_error=0, index=0, xor=0.
  - Any other accepted byte is discarded.
- COUNT: on accept, xor^=byte.
  - N > 2**ADDR_WIDTH -> load_error=1, cpu_hold=0, go to IDLE.
  - N == 0 -> CHECK.
  - Otherwise latch N, go to HI.
- HI: on accept, latch byte, xor^=byte, go to LO.
- LO: on accept, xor^=byte, go to WRITE.
- WRITE (exactly one cycle, rx_ready=0):
  - mem_we=1, mem_waddr=index, mem_wdata={hi,lo}[INSTR_WIDTH-1:0]; upper bits of hi beyond INSTR_WIDTH-8 are ignored.
  - index+1; if index+1 == N -> CHECK, else -> HI.
  - Write latency: LO byte accepted at edge t -> mem_we high during cycle t+1.
- CHECK: on accept, compare byte with xor, then cpu_hold=0 and go to IDLE.
  - Equal -> load_done=1 for exactly one cycle.
  - Not equal -> load_error=1.
  - Words already written are not rolled back.
- rx_ready=1 in every state except WRITE.
- rx_valid may drop between bytes for any number of cycles; state is held.
- rx_data is ignored when rx_valid=0.
- Index never wraps: N = 2**ADDR_WIDTH writes addresses 0..2**ADDR_WIDTH-1, then goes to CHECK. The counter is ADDR_WIDTH+1 bits wide.
- mem_waddr and mem_wdata hold their last values when mem_we=0.
- A 0xA5 byte received mid-frame is treated as data, not a restart.
- load_error stays high through IDLE until the next header is accepted.

Test Plan:
- Reset: assert reset for 2 cycles with rx_valid=1 and rx_data=0xA5 -> all outputs hold their reset values, no state change, cpu_hold=0.
- Good load (ADDR_WIDTH=4, INSTR_WIDTH=12), bytes A5 02 0A BC 01 23 96 back-to-back ->
  - mem_we pulses twice: addr0=0xABC, addr1=0x123, each one cycle after its LO byte.
  - rx_ready low only in those two cycles; cpu_hold high from header to checksum.
  - load_done pulses once; load_error=0.
- Bad checksum, A5 01 FA 55 00 ->
  - One write: addr0=0xA55 (upper nibble of 0xFA dropped).
  - load_error=1 and stays high; no load_done; cpu_hold=0.
  - A following good frame clears load_error.
- Oversize count, A5 11 -> load_error=1 immediately, no mem_we, cpu_hold=0, back in IDLE; next 0xA5 is accepted as a header.
- Junk and gaps, bytes 00 FF 3C in IDLE then a good frame with random 0..5 cycle rx_valid gaps -> junk is ignored; writes and checksum result are identical to the back-to-back case.
- Boundaries:
  - A5 00 00 -> load_done with zero writes.
  - A5 10 followed by 16 words -> writes addr 0..15 with no wrap, then CHECK.
  - Reset asserted after the 3rd word -> no further writes; a new frame writes from addr 0.
